// File: rtl/inst_encode_if.sv
// inst_encode_if -- request/response bundle for the RV32 instruction encoder.
//
// Request side  : ReqValid/ReqReady handshake carrying ReqOp, ReqRd, ReqRs1,
//                 ReqRs2 and ReqImm.
// Response side : OutValid/OutReady handshake presenting the FIFO head as
//                 OutInst/OutUndef, plus the FIFO occupancy Count.
//
// Modports:
//   master -- the requester/consumer (drives requests, takes results)
//   slave  -- the encoder itself
interface inst_encode_if;
  logic        ReqValid;
  logic        ReqReady;
  logic [4:0]  ReqOp;
  logic [4:0]  ReqRd;
  logic [4:0]  ReqRs1;
  logic [4:0]  ReqRs2;
  logic [31:0] ReqImm;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] OutInst;
  logic        OutUndef;
  logic [2:0]  Count;

  modport master (
    output ReqValid, ReqOp, ReqRd, ReqRs1, ReqRs2, ReqImm, OutReady,
    input  ReqReady, OutValid, OutInst, OutUndef, Count
  );

  modport slave (
    input  ReqValid, ReqOp, ReqRd, ReqRs1, ReqRs2, ReqImm, OutReady,
    output ReqReady, OutValid, OutInst, OutUndef, Count
  );
endinterface

// File: rtl/inst_encode.sv
// inst_encode -- encodes abstract operation requests into RV32I/M machine
// words and queues the results in a 4-entry in-order FIFO.
//
// Ports:
//   Clk   -- sole clock, rising edge
//   Rst_n -- synchronous active-low reset
//   bus   -- inst_encode_if.slave: request handshake (ReqValid/ReqReady,
//            ReqOp/ReqRd/ReqRs1/ReqRs2/ReqImm), result handshake
//            (OutValid/OutReady, OutInst/OutUndef) and occupancy Count.
//
// Configuration macro: INST_ENCODE_MULDIV_EN
//   defined   -- ops 8..11 encode MUL/MULH/DIV/REM
//   undefined -- ops 8..11 are reported as undefined (OutInst=0, OutUndef=1)
module inst_encode (
  input  logic         Clk,
  input  logic         Rst_n,
  inst_encode_if.slave bus
);

  typedef enum logic [2:0] {
    FMT_X, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
  } fmt_e;

  // ---------------------------------------------------------------- encoder
  fmt_e        fmt;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] enc_inst;
  logic        enc_undef;

  always_comb begin
    fmt = FMT_X;
    opc = 7'h00;
    f3  = 3'd0;
    f7  = 7'h00;
    case (bus.ReqOp)
      5'd0:  begin fmt = FMT_R;  opc = 7'h33; f3 = 3'd0; end
      5'd1:  begin fmt = FMT_R;  opc = 7'h33; f3 = 3'd0; f7 = 7'h20; end
      5'd2:  begin fmt = FMT_R;  opc = 7'h33; f3 = 3'd1; end
      5'd3:  begin fmt = FMT_R;  opc = 7'h33; f3 = 3'd2; end
      5'd4:  begin fmt = FMT_R;  opc = 7'h33; f3 = 3'd4; end
      5'd5:  begin fmt = FMT_R;  opc = 7'h33; f3 = 3'd5; end
      5'd6:  begin fmt = FMT_R;  opc = 7'h33; f3 = 3'd6; end
      5'd7:  begin fmt = FMT_R;  opc = 7'h33; f3 = 3'd7; end
`ifdef INST_ENCODE_MULDIV_EN
      5'd8:  begin fmt = FMT_R;  opc = 7'h33; f3 = 3'd0; f7 = 7'h01; end
      5'd9:  begin fmt = FMT_R;  opc = 7'h33; f3 = 3'd1; f7 = 7'h01; end
      5'd10: begin fmt = FMT_R;  opc = 7'h33; f3 = 3'd4; f7 = 7'h01; end
      5'd11: begin fmt = FMT_R;  opc = 7'h33; f3 = 3'd6; f7 = 7'h01; end
`endif
      5'd12: begin fmt = FMT_I;  opc = 7'h13; f3 = 3'd0; end
      5'd13: begin fmt = FMT_SH; opc = 7'h13; f3 = 3'd1; end
      5'd14: begin fmt = FMT_I;  opc = 7'h13; f3 = 3'd2; end
      5'd15: begin fmt = FMT_I;  opc = 7'h13; f3 = 3'd4; end
      5'd16: begin fmt = FMT_SH; opc = 7'h13; f3 = 3'd5; end
      5'd17: begin fmt = FMT_I;  opc = 7'h13; f3 = 3'd6; end
      5'd18: begin fmt = FMT_I;  opc = 7'h13; f3 = 3'd7; end
      5'd19: begin fmt = FMT_I;  opc = 7'h03; f3 = 3'd0; end
      5'd20: begin fmt = FMT_I;  opc = 7'h03; f3 = 3'd1; end
      5'd21: begin fmt = FMT_I;  opc = 7'h03; f3 = 3'd2; end
      5'd22: begin fmt = FMT_S;  opc = 7'h23; f3 = 3'd2; end
      5'd23: begin fmt = FMT_B;  opc = 7'h63; f3 = 3'd0; end
      5'd24: begin fmt = FMT_B;  opc = 7'h63; f3 = 3'd4; end
      5'd25: begin fmt = FMT_B;  opc = 7'h63; f3 = 3'd6; end
      5'd26: begin fmt = FMT_U;  opc = 7'h37; end
      5'd27: begin fmt = FMT_J;  opc = 7'h6F; end
      5'd28: begin fmt = FMT_I;  opc = 7'h67; f3 = 3'd0; end
      default: fmt = FMT_X;
    endcase
  end

  always_comb begin
    enc_inst  = 32'h0;
    enc_undef = 1'b0;
    case (fmt)
      FMT_R:  enc_inst = {f7, bus.ReqRs2, bus.ReqRs1, f3, bus.ReqRd, opc};
      FMT_I:  enc_inst = {bus.ReqImm[11:0], bus.ReqRs1, f3, bus.ReqRd, opc};
      // Shift-immediates carry only a 5-bit shamt; the upper field is zero.
      FMT_SH: enc_inst = {7'h00, bus.ReqImm[4:0], bus.ReqRs1, f3, bus.ReqRd, opc};
      FMT_S:  enc_inst = {bus.ReqImm[11:5], bus.ReqRs2, bus.ReqRs1, f3,
                          bus.ReqImm[4:0], opc};
      FMT_B:  enc_inst = {bus.ReqImm[12], bus.ReqImm[10:5], bus.ReqRs2, bus.ReqRs1,
                          f3, bus.ReqImm[4:1], bus.ReqImm[11], opc};
      FMT_U:  enc_inst = {bus.ReqImm[31:12], bus.ReqRd, opc};
      FMT_J:  enc_inst = {bus.ReqImm[20], bus.ReqImm[10:1], bus.ReqImm[11],
                          bus.ReqImm[19:12], bus.ReqRd, opc};
      default: enc_undef = 1'b1;
    endcase
  end

  // ------------------------------------------------------------------- FIFO
  logic [32:0] mem_q [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  // Holds ReqReady low through reset and for the edge that ends it.
  logic        live_q, live_d;
  logic        push, pop;

  assign bus.ReqReady = live_q && (count_q != 3'd4);
  assign bus.OutValid = (count_q != 3'd0);
  assign bus.Count    = count_q;
  assign bus.OutInst  = mem_q[rd_ptr_q][31:0];
  assign bus.OutUndef = mem_q[rd_ptr_q][32];

  assign push = bus.ReqValid && bus.ReqReady;
  assign pop  = bus.OutValid && bus.OutReady;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
    live_d   = 1'b1;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      live_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      live_q   <= live_d;
    end
  end

  // Storage carries no reset; a push on a reset edge is simply not written.
  always_ff @(posedge Clk) begin
    if (Rst_n && push) begin
      mem_q[wr_ptr_q] <= {enc_undef, enc_inst};
    end
  end

endmodule

// File: tb/tb_inst_encode.sv
module tb_inst_encode;

  logic Clk;
  logic Rst_n;
  inst_encode_if bus();

  inst_encode dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;
  int since_rst = 0;
  logic [32:0] sb [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  // Reference encoder: one complete instruction word per operation.
  function automatic logic [32:0] model(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [31:0] im);
    logic [31:0] w;
    logic u;
    w = 32'h0;
    u = 1'b0;
    case (op)
      5'd0:  w = {7'h00, rs2, rs1, 3'h0, rd, 7'h33};
      5'd1:  w = {7'h20, rs2, rs1, 3'h0, rd, 7'h33};
      5'd2:  w = {7'h00, rs2, rs1, 3'h1, rd, 7'h33};
      5'd3:  w = {7'h00, rs2, rs1, 3'h2, rd, 7'h33};
      5'd4:  w = {7'h00, rs2, rs1, 3'h4, rd, 7'h33};
      5'd5:  w = {7'h00, rs2, rs1, 3'h5, rd, 7'h33};
      5'd6:  w = {7'h00, rs2, rs1, 3'h6, rd, 7'h33};
      5'd7:  w = {7'h00, rs2, rs1, 3'h7, rd, 7'h33};
`ifdef INST_ENCODE_MULDIV_EN
      5'd8:  w = {7'h01, rs2, rs1, 3'h0, rd, 7'h33};
      5'd9:  w = {7'h01, rs2, rs1, 3'h1, rd, 7'h33};
      5'd10: w = {7'h01, rs2, rs1, 3'h4, rd, 7'h33};
      5'd11: w = {7'h01, rs2, rs1, 3'h6, rd, 7'h33};
`endif
      5'd12: w = {im[11:0], rs1, 3'h0, rd, 7'h13};
      5'd13: w = {7'h00, im[4:0], rs1, 3'h1, rd, 7'h13};
      5'd14: w = {im[11:0], rs1, 3'h2, rd, 7'h13};
      5'd15: w = {im[11:0], rs1, 3'h4, rd, 7'h13};
      5'd16: w = {7'h00, im[4:0], rs1, 3'h5, rd, 7'h13};
      5'd17: w = {im[11:0], rs1, 3'h6, rd, 7'h13};
      5'd18: w = {im[11:0], rs1, 3'h7, rd, 7'h13};
      5'd19: w = {im[11:0], rs1, 3'h0, rd, 7'h03};
      5'd20: w = {im[11:0], rs1, 3'h1, rd, 7'h03};
      5'd21: w = {im[11:0], rs1, 3'h2, rd, 7'h03};
      5'd22: w = {im[11:5], rs2, rs1, 3'h2, im[4:0], 7'h23};
      5'd23: w = {im[12], im[10:5], rs2, rs1, 3'h0, im[4:1], im[11], 7'h63};
      5'd24: w = {im[12], im[10:5], rs2, rs1, 3'h4, im[4:1], im[11], 7'h63};
      5'd25: w = {im[12], im[10:5], rs2, rs1, 3'h6, im[4:1], im[11], 7'h63};
      5'd26: w = {im[31:12], rd, 7'h37};
      5'd27: w = {im[20], im[10:1], im[11], im[19:12], rd, 7'h6F};
      5'd28: w = {im[11:0], rs1, 3'h0, rd, 7'h67};
      default: u = 1'b1;
    endcase
    return {u, w};
  endfunction

  // Scoreboard: looks at the cycle ahead of each rising edge and decides
  // what that edge will pop and push.
  always @(negedge Clk) begin
    if (!Rst_n) begin
      sb.delete();
      since_rst = 0;
    end else begin
      if (since_rst < 2) since_rst++;
      check("count", bus.Count, sb.size());
      check("out_valid", bus.OutValid, sb.size() > 0);
      if (since_rst >= 2) check("req_ready", bus.ReqReady, sb.size() < 4);
      if (bus.OutValid && bus.OutReady && sb.size() > 0) begin
        logic [32:0] e;
        e = sb.pop_front();
        check("out_inst", bus.OutInst, e[31:0]);
        check("out_undef", bus.OutUndef, e[32]);
        $display("pop  inst=0x%08h undef=%0d (expect 0x%08h/%0d)",
                 bus.OutInst, bus.OutUndef, e[31:0], e[32]);
      end
      if (bus.ReqValid && bus.ReqReady)
        sb.push_back(model(bus.ReqOp, bus.ReqRd, bus.ReqRs1, bus.ReqRs2, bus.ReqImm));
    end
  end

  task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    bus.ReqOp = op; bus.ReqRd = rd; bus.ReqRs1 = rs1; bus.ReqRs2 = rs2; bus.ReqImm = imm;
    bus.ReqValid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge Clk);
      if (bus.ReqReady) acc = 1;
      @(posedge Clk);
      #1;
      n++;
    end
    bus.ReqValid = 1'b0;
    if (!acc) check("accept_timeout", bus.ReqReady, 1);
    else $display("push op=%0d rd=%0d rs1=%0d rs2=%0d imm=0x%08h", op, rd, rs1, rs2, imm);
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.OutReady = 1'b1;
    while (bus.Count != 0 && n < 20) begin
      @(posedge Clk);
      #1;
      n++;
    end
    bus.OutReady = 1'b0;
    check("drain", bus.Count, 0);
  endtask

  // Single request into an empty FIFO, head compared against a fixed word.
  task automatic direct(input string tag, input logic [4:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                        input logic [31:0] exp_inst, input logic exp_undef);
    bus.OutReady = 1'b0;
    send(op, rd, rs1, rs2, imm);
    check({tag, "_valid"}, bus.OutValid, 1);
    check({tag, "_inst"}, bus.OutInst, exp_inst);
    check({tag, "_undef"}, bus.OutUndef, exp_undef);
    drain();
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    @(posedge Clk);
    #1;
    check("rst_count", bus.Count, 0);
    check("rst_valid", bus.OutValid, 0);
    check("rst_ready", bus.ReqReady, 0);
    Rst_n = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    check("rst_ready_after", bus.ReqReady, 1);
  endtask

  initial begin
    Rst_n = 1'b0;
    bus.ReqValid = 1'b0; bus.OutReady = 1'b0;
    bus.ReqOp = '0; bus.ReqRd = '0; bus.ReqRs1 = '0; bus.ReqRs2 = '0; bus.ReqImm = '0;
    @(posedge Clk);
    #1;
    do_reset();

    direct("add",  5'd0,  5'd3, 5'd1, 5'd2, 32'h0, 32'h002081B3, 1'b0);
    direct("addi", 5'd12, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0);
    direct("sw",   5'd22, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020A423, 1'b0);
    direct("beq",  5'd23, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0);
    direct("undef30", 5'd30, 5'd1, 5'd2, 5'd3, 32'h1234, 32'h0, 1'b1);
`ifdef INST_ENCODE_MULDIV_EN
    direct("mul",  5'd8,  5'd5, 5'd6, 5'd7, 32'h0, 32'h027302B3, 1'b0);
`else
    direct("mul",  5'd8,  5'd5, 5'd6, 5'd7, 32'h0, 32'h0, 1'b1);
`endif

    // Fill to capacity, then hold a fifth request until space opens.
    for (int i = 0; i < 4; i++) send(5'd12, 5'(i + 1), 5'd2, 5'd0, 32'(i * 3));
    check("full_count", bus.Count, 4);
    check("full_ready", bus.ReqReady, 0);
    bus.ReqOp = 5'd26; bus.ReqRd = 5'd9; bus.ReqImm = 32'hABCDE123; bus.ReqValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk);
      #1;
      check("hold_count", bus.Count, 4);
    end
    bus.OutReady = 1'b1;
    send(5'd26, 5'd9, 5'd0, 5'd0, 32'hABCDE123);
    drain();

    // Reset with three entries stored.
    for (int i = 0; i < 3; i++) send(5'd27, 5'd1, 5'd0, 5'd0, 32'h000FF800 + 32'(i * 2));
    check("pre_rst_count", bus.Count, 3);
    do_reset();
    direct("post_rst_addi", 5'd12, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0);

    // Random traffic with random back-pressure and one reset pulse.
    for (int c = 0; c < 400; c++) begin
      bus.ReqValid = 1'($urandom_range(0, 1));
      bus.ReqOp  = 5'($urandom);
      bus.ReqRd  = 5'($urandom);
      bus.ReqRs1 = 5'($urandom);
      bus.ReqRs2 = 5'($urandom);
      bus.ReqImm = $urandom;
      bus.OutReady = ($urandom_range(0, 2) != 0);
      Rst_n = (c != 200);
      @(posedge Clk);
      #1;
    end
    bus.ReqValid = 1'b0;
    Rst_n = 1'b1;
    drain();
    @(negedge Clk);
    check("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_encode.md
INST_ENCODE -- requirements
Module: inst_encode

Interface
REQ-001 Clk  input  1  sole clock; all state updates on rising edge.
REQ-002 Rst_n  input  1  reset, synchronous, active-low.
REQ-003 ReqValid  input  1  encode request present.
REQ-004 ReqReady  output  1  block can accept a request this cycle.
REQ-005 ReqOp  input  5  operation code (table REQ-012).
REQ-006 ReqRd / ReqRs1 / ReqRs2  input  5 each  register indices.
REQ-007 ReqImm  input  32  immediate or byte offset, two's complement.
REQ-008 OutValid  output  1  head FIFO entry valid.
REQ-009 OutReady  input  1  consumer takes head entry.
REQ-010 OutInst / OutUndef  output  32 / 1  encoded RV32 instruction; unencodable-op flag.
REQ-011 Count  output  3  FIFO occupancy, 0..4.

Function
REQ-012 ReqOp map:
- R-type, opcode 0x33: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 XOR, 5 SRL, 6 OR, 7 AND, 8 MUL, 9 MULH, 10 DIV, 11 REM.
- I-type ALU, opcode 0x13: 12 ADDI, 13 SLLI, 14 SLTI, 15 XORI, 16 SRLI, 17 ORI, 18 ANDI.
- Loads, opcode 0x03: 19 LB, 20 LH, 21 LW.
- 22 SW (0x23).
- Branches, opcode 0x63: 23 BEQ, 24 BLT, 25 BLTU.
- 26 LUI (0x37), 27 JAL (0x6F), 28 JALR (0x67).
- 29-31 undefined.
REQ-013 Funct3/Funct7:
- ADD/SUB/MUL f3 0; SUB f7 0x20; M ops f7 0x01; all other R ops f7 0x00.
- SLL/MULH f3 1; SLT f3 2; XOR/DIV f3 4; SRL f3 5; OR/REM f3 6; AND f3 7.
- I-type ALU ops use the same f3 as their R counterpart.
- LB/LH/LW f3 0/1/2; SW f3 2; BEQ/BLT/BLTU f3 0/4/6; JALR f3 0.
REQ-014 Field packing:
- R: {f7,rs2,rs1,f3,rd,op}.
- I: {imm[11:0],rs1,f3,rd,op}; SLLI/SRLI use {7'h00,imm[4:0]} in place of imm[11:0].
- S: {imm[11:5],rs2,rs1,f3,imm[4:0],op}.
- B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}.
- U: {imm[31:12],rd,op}.
- J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
- Unused imm bits are silently dropped; there is no range check.
REQ-015 Undefined ReqOp: the entry is still enqueued, with OutInst=32'h0 and OutUndef=1.
REQ-016 Request accepted on an edge where ReqValid && ReqReady; the encoding is computed combinationally and written into the FIFO on that edge.
REQ-017 FIFO depth 4, in-order. ReqReady = (Count<4), independent of OutReady.
REQ-018 OutValid = (Count>0); OutInst/OutUndef always reflect the head entry.
REQ-019 Pop on OutValid && OutReady.
REQ-020 Latency: a request accepted at edge N into an empty FIFO presents OutValid=1 after edge N.
REQ-021 Simultaneous push and pop: Count unchanged, and the head advances to the next entry. With Count=1, the new entry becomes the head.
REQ-022 Read and write pointers are 2 bits and wrap 3->0; Count never exceeds 4 or goes below 0.
REQ-023 Request inputs are ignored while ReqReady=0 or ReqValid=0.

Reset
REQ-024 On an edge with Rst_n=0: pointers=0, Count=0, OutValid=0, ReqReady=0. Stored entries are discarded, including any push or pop requested on that edge.
REQ-025 After Rst_n returns to 1: ReqReady=1 from the first following cycle. OutInst/OutUndef are don't-care while OutValid=0.

Configuration
REQ-026 Macro INST_ENCODE_MULDIV_EN:
- Defined: ops 8-11 encode per REQ-013.
- Undefined: ops 8-11 are treated as undefined per REQ-015. All other behaviour is identical.

Verification
REQ-027 ADD rd=3, rs1=1, rs2=2 -> OutInst 0x002081B3, OutUndef 0, OutValid the next cycle.
REQ-028 ADDI rd=1, rs1=0, imm=5 -> 0x00500093; SW rs2=2, rs1=1, imm=8 -> 0x0020A423.
REQ-029 BEQ rs1=1, rs2=2, imm=0xFFFFFFFC -> 0xFE208EE3; ReqOp=30 -> OutInst 0, OutUndef 1.
REQ-030 MUL rd=5, rs1=6, rs2=7 -> 0x027302B3 with the macro defined; OutInst 0, OutUndef 1 without it.
REQ-031 Five back-to-back requests with OutReady=0 -> ReqReady drops after the 4th, Count=4, 5th not accepted. Then OutReady=1 -> entries pop in order, and the 5th is accepted only once Count<4.
REQ-032 Rst_n=0 for one cycle with Count=3 -> next cycle Count=0, OutValid=0; a following request is encoded correctly.
